fp_addsub_arbiter: RTL and testbench
====================================

// Module: fp_addsub_arbiter
// PURPOSE
//   Shares one single-precision FP add/sub unit (1-cycle registered, dataa/datab/result) among NUM_REQ requesters.
//   Round-robin arbitration issues at most one operation per clock.
//   The arbiter tracks in-flight operations in a tag pipeline and returns each result to its originator.
//   Sits between the custom-instruction masters and the shared FP datapath.
// PARAMETERS
//   NUM_REQ       4   number of requesters (2..8)
//   UNIT_LATENCY  1   clock edges from operands presented to unit_result valid (1..4)
// PORTS
//   clk         in   1          system clock, all state on rising edge
//   reset       in   1          asynchronous, active-high reset
//   req_valid   in   NUM_REQ    requester i has an operation pending
//   req_ready   out  NUM_REQ    one-hot grant; accept when req_valid[i]&req_ready[i]
//   req_dataa   in   32*NUM_REQ operand A of requester i, bits [32i+31:32i]
//   req_datab   in   32*NUM_REQ operand B of requester i
//   req_sub     in   NUM_REQ    1 = A-B, 0 = A+B
//   unit_dataa  out  32         operand A to shared unit
//   unit_datab  out  32         operand B to shared unit (sign pre-flipped for subtract)
//   unit_result in   32         result from shared unit
//   rsp_valid   out  NUM_REQ    one-hot, 1-cycle pulse: result for requester i
//   rsp_result  out  32         result word, valid while any rsp_valid bit is set
//   busy        out  1          any operation in flight
// BEHAVIOUR
//   Reset (async):
//     - rr_ptr=0; tag pipeline valid bits cleared; rsp_valid=0; busy=0.
//     - req_ready and unit operands are combinational; they are 0 while reset is high.
//   Arbitration (combinational, every cycle):
//     - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit g is granted.
//     - req_ready=onehot(g); with no request pending, req_ready=0.
//     - Grant does not depend on pipeline occupancy: the unit is fully pipelined, so there is no backpressure.
//   Issue:
//     - unit_dataa=req_dataa[g].
//     - unit_datab=req_datab[g] with bit31 XOR req_sub[g].
//     - Both are 0 when nothing is granted.
//     - At the accepting edge: rr_ptr<=(g+1) mod NUM_REQ. rr_ptr holds when nothing is granted.
//     - Requester must hold dataa/datab/sub stable while req_valid=1 and not yet accepted.
//   Tag pipeline:
//     - Depth UNIT_LATENCY; each stage is {vld, id[$clog2(NUM_REQ)-1:0]}.
//     - Stage0<={granted,g} every edge; stage k<=stage k-1.
//   Response:
//     - rsp_valid=onehot(tail.id)&tail.vld (registered).
//     - rsp_result=unit_result when tail.vld, else 0.
//     - The operation accepted at edge E appears at the tail after edge E+UNIT_LATENCY-1, aligned with unit_result.
//     - Throughput: 1 op/cycle.
//     - Responses are not backpressured; requesters must sink rsp_valid.
//   busy: OR of all stage vld bits.
//   Ordering:
//     - Results return strictly in issue order.
//     - Back-to-back grants to the same requester are allowed when it is the only one requesting.
//   Boundaries:
//     - rr_ptr wraps from NUM_REQ-1 to 0.
//     - A request newly raised at rr_ptr in the same cycle as a lower-index request wins.
//     - An issue and a response for the same requester in one cycle are independent.
//   Reset mid-operation: all in-flight results are discarded, so no rsp_valid pulse follows.
//   Zero handling: the unit returns the nonzero operand, so 0-B yields -B via the sign flip (no special casing).
// TESTING
//   1. Single op:
//      - Stimulus: req0 1.0(3F800000)+2.0(40000000).
//      - Required: rsp_valid[0] one cycle after accept, result 40400000; busy pulses 1 cycle.
//   2. Subtract:
//      - Stimulus: req1 3.0(40400000)-1.0(3F800000).
//      - Required: unit_datab=BF800000 during grant; rsp_result 40000000 on rsp_valid[1].
//   3. Round-robin:
//      - Stimulus: all 4 valid continuously from reset.
//      - Required: grants 0,1,2,3,0,... one per cycle; rsp_valid follows the same order.
//   4. Fairness/wrap:
//      - Stimulus: rr_ptr=3, req_valid=4'b1001.
//      - Required: grant 3, then 0; rr_ptr returns to 1.
//   5. Reset mid-flight:
//      - Stimulus: assert reset the cycle after accepting an op.
//      - Required: no rsp_valid pulse, busy=0, rr_ptr=0.
//   6. Zero operand:
//      - Stimulus: req2 0(00000000)-0.5(3F000000).
//      - Required: rsp_result BF000000 on rsp_valid[2].

Source files
------------

// File: rtl/fp_addsub_arbiter.sv
// Round-robin front end for one shared, fully pipelined single-precision add/sub unit.
// Each issued operation carries a requester tag down a pipeline that matches the unit latency.
module fp_addsub_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int UNIT_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_dataa,
  input  logic [32*NUM_REQ-1:0]   req_datab,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic [31:0]             unit_dataa,
  output logic [31:0]             unit_datab,
  input  logic [31:0]             unit_result,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_result,
  output logic                    busy
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]     rr_ptr_reg;
  logic [31:0]        dataa_arr [NUM_REQ];
  logic [31:0]        datab_arr [NUM_REQ];
  logic [IDW-1:0]     cand_idx  [NUM_REQ];
  logic [NUM_REQ-1:0] cand_vld;
  logic               grant_found;
  logic [IDW-1:0]     grant_idx;

  logic [UNIT_LATENCY-1:0]          stage_vld_reg;
  logic [UNIT_LATENCY-1:0][IDW-1:0] stage_id_reg;
  logic                             tail_vld;
  logic [IDW-1:0]                   tail_id;

  // Subtraction is folded into the operand path by flipping B's sign bit.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_operands
      assign dataa_arr[gi] = req_dataa[32*gi +: 32];
      assign datab_arr[gi] = {req_datab[32*gi+31] ^ req_sub[gi], req_datab[32*gi +: 31]};
    end
  endgenerate

  // Candidate gi is the requester gi positions after rr_ptr, wrapped.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_candidates
      logic [IDW:0] sum;
      assign sum           = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
      assign cand_idx[gi]  = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ))
                                                        : IDW'(sum);
      assign cand_vld[gi]  = req_valid[cand_idx[gi]];
    end
  endgenerate

  // Scan from farthest to nearest so the nearest pending candidate wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
    if (reset) begin
      grant_found = 1'b0;
      grant_idx   = '0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_found && (grant_idx == IDW'(gi));
    end
  endgenerate

  assign unit_dataa = grant_found ? dataa_arr[grant_idx] : 32'h0;
  assign unit_datab = grant_found ? datab_arr[grant_idx] : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else if (grant_found) begin
      rr_ptr_reg <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  // Tag pipeline tracks the unit's internal stages one-for-one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_vld_reg <= '0;
      stage_id_reg  <= '0;
    end else begin
      stage_vld_reg[0] <= grant_found;
      stage_id_reg[0]  <= grant_idx;
      for (int k = 1; k < UNIT_LATENCY; k++) begin
        stage_vld_reg[k] <= stage_vld_reg[k-1];
        stage_id_reg[k]  <= stage_id_reg[k-1];
      end
    end
  end

  assign tail_vld = stage_vld_reg[UNIT_LATENCY-1];
  assign tail_id  = stage_id_reg[UNIT_LATENCY-1];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = tail_vld && (tail_id == IDW'(gi));
    end
  endgenerate

  assign rsp_result = tail_vld ? unit_result : 32'h0;
  assign busy       = |stage_vld_reg;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench: a table-driven stand-in for the 1-cycle FP unit plus per-feature tasks.
module tb_fp_addsub_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_dataa;
  logic [127:0] req_datab;
  logic [3:0]   req_sub;
  logic [31:0]  unit_dataa;
  logic [31:0]  unit_datab;
  logic [31:0]  unit_result;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_result;
  logic         busy;

  int checks = 0;
  int errors = 0;

  fp_addsub_arbiter #(.NUM_REQ(4), .UNIT_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dataa(req_dataa), .req_datab(req_datab), .req_sub(req_sub),
    .unit_dataa(unit_dataa), .unit_datab(unit_datab), .unit_result(unit_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Known sums for the operand pairs used below; anything else is flagged by DEADBEEF.
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] key;
    key = {a, b};
    case (key)
      64'h3F800000_40000000: return 32'h40400000;
      64'h40400000_BF800000: return 32'h40000000;
      64'h00000000_BF000000: return 32'hBF000000;
      64'h3F800000_3F800000: return 32'h40000000;
      64'h40000000_40000000: return 32'h40800000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) unit_result <= fp_model(unit_dataa, unit_datab);

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_dataa[32*i +: 32] = a;
    req_datab[32*i +: 32] = b;
    req_sub[i]            = s;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'b1111;
    req_dataa = {4{32'h3F800000}}; req_datab = {4{32'h40000000}}; req_sub = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (unit_dataa !== 32'h0) begin errors++; $display("FAIL reset_unit_dataa got %h exp 00000000", unit_dataa); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk);
    req_valid = 4'b0; reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_op();
    @(negedge clk);
    set_req(0, 32'h3F800000, 32'h40000000, 1'b0); req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    checks++; if (unit_dataa !== 32'h3F800000) begin errors++; $display("FAIL single_dataa got %h exp 3F800000", unit_dataa); end
    checks++; if (unit_datab !== 32'h40000000) begin errors++; $display("FAIL single_datab got %h exp 40000000", unit_datab); end
    @(posedge clk); #1; req_valid = 4'b0; #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %b exp 0001", rsp_valid); end
    checks++; if (rsp_result !== 32'h40400000) begin errors++; $display("FAIL single_result got %h exp 40400000", rsp_result); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL single_rsp_clear got %b exp 0000", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_clear got %b exp 0", busy); end
    $display("test_single_op 1.0+2.0 result %h", 32'h40400000);
  endtask

  task automatic test_subtract();
    @(negedge clk);
    set_req(1, 32'h40400000, 32'h3F800000, 1'b1); req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sub_ready got %b exp 0010", req_ready); end
    checks++; if (unit_datab !== 32'hBF800000) begin errors++; $display("FAIL sub_datab got %h exp BF800000", unit_datab); end
    @(posedge clk); #1; req_valid = 4'b0; #1;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL sub_rsp_valid got %b exp 0010", rsp_valid); end
    checks++; if (rsp_result !== 32'h40000000) begin errors++; $display("FAIL sub_result got %h exp 40000000", rsp_result); end
    @(posedge clk);
    $display("test_subtract 3.0-1.0 checked");
  endtask

  task automatic test_zero_operand();
    @(negedge clk);
    set_req(2, 32'h00000000, 32'h3F000000, 1'b1); req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL zero_ready got %b exp 0100", req_ready); end
    @(posedge clk); #1; req_valid = 4'b0; #1;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL zero_rsp_valid got %b exp 0100", rsp_valid); end
    checks++; if (rsp_result !== 32'hBF000000) begin errors++; $display("FAIL zero_result got %h exp BF000000", rsp_result); end
    @(posedge clk);
    $display("test_zero_operand 0-0.5 checked");
  endtask

  // Pointer sits at 3 after the previous three single-requester issues.
  task automatic test_wrap();
    @(negedge clk);
    set_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
    set_req(3, 32'h3F800000, 32'h40000000, 1'b0);
    req_valid = 4'b1001; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b exp 1000", req_ready); end
    @(posedge clk); #1; req_valid = 4'b0001; #1;
    checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL wrap_rsp3 got %b exp 1000", rsp_valid); end
    checks++; if (rsp_result !== 32'h40400000) begin errors++; $display("FAIL wrap_res3 got %h exp 40400000", rsp_result); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_second got %b exp 0001", req_ready); end
    @(posedge clk); #1; req_valid = 4'b1111; #1;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL wrap_rsp0 got %b exp 0001", rsp_valid); end
    checks++; if (rsp_result !== 32'h40000000) begin errors++; $display("FAIL wrap_res0 got %h exp 40000000", rsp_result); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ptr_after got %b exp 0010", req_ready); end
    req_valid = 4'b0;
    @(posedge clk);
    $display("test_wrap grants 3 then 0, pointer at 1");
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_res [4];
    exp_res[0] = 32'h40000000; exp_res[1] = 32'h40800000;
    exp_res[2] = 32'h40400000; exp_res[3] = 32'h40000000;
    reset = 1'b1; req_valid = 4'b0;
    set_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
    set_req(1, 32'h40000000, 32'h40000000, 1'b0);
    set_req(2, 32'h3F800000, 32'h40000000, 1'b0);
    set_req(3, 32'h40400000, 32'h3F800000, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_grant c=%0d got %b exp %b", c, req_ready, 4'(1 << (c % 4))); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_rsp c=%0d got %b exp %b", c, rsp_valid, 4'(1 << (c % 4))); end
      checks++; if (rsp_result !== exp_res[c % 4]) begin errors++; $display("FAIL rr_result c=%0d got %h exp %h", c, rsp_result, exp_res[c % 4]); end
      $display("round_robin cycle %0d grant %0d result %h", c, c % 4, rsp_result);
    end
    req_valid = 4'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_idle got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_grant c=%0d got %b exp 0010", c, req_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 4'b0010 || rsp_result !== 32'h40800000) begin
        errors++; $display("FAIL b2b_rsp c=%0d got %b/%h exp 0010/40800000", c, rsp_valid, rsp_result);
      end
      $display("back_to_back cycle %0d grant 1", c);
    end
    req_valid = 4'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid_flight();
    @(negedge clk);
    req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant got %b exp 0010", req_ready); end
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 4'b1111; #1;
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL mid_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL mid_ready_in_reset got %b exp 0000", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL mid_rsp_after got %b exp 0000", rsp_valid); end
    @(negedge clk);
    reset = 1'b0; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_zero got %b exp 0001", req_ready); end
    @(posedge clk); #1; req_valid = 4'b0; #1;
    checks++; if (rsp_valid !== 4'b0001 || rsp_result !== 32'h40000000) begin
      errors++; $display("FAIL mid_first_rsp got %b/%h exp 0001/40000000", rsp_valid, rsp_result);
    end
    @(posedge clk);
    $display("test_reset_mid_flight done");
  endtask

  initial begin
    req_valid = 4'b0; req_dataa = '0; req_datab = '0; req_sub = '0; reset = 1'b1;
    test_reset();
    test_single_op();
    test_subtract();
    test_zero_operand();
    test_wrap();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
